// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader.
//   state_t          : burst FSM encoding (IDLE / BURST / DRAIN)
//   DEF_DATA_WIDTH   : default beat width
//   DEF_LEN_WIDTH    : default burst length field width (beats minus 1)
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 8;

endpackage

// File: rtl/fifo_burst_reader_beat_skid_buf.sv
// Two-entry registered output buffer for the burst reader.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push         : write push_data into the tail (caller never pushes into a
//                  full buffer unless the head is accepted in the same cycle)
//   push_data    : word to store
//   ready        : downstream accept
//   valid        : head entry holds a beat
//   data         : head entry contents (registered)
//   count        : number of stored entries, 0..2
// Valid/ready: a beat moves when valid & ready are both high at a rising edge;
// while valid is high and ready is low, valid and data hold unchanged.
module beat_skid_buf #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             accept;

  assign valid  = (count_q != 2'd0);
  assign accept = valid & ready;
  assign data   = head_q;
  assign count  = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, accept})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Accept frees the head; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains burst-length groups of beats from a synchronous FIFO head and presents
// them downstream with a generated last flag.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   fifo_data_i      : FIFO head word (read combinationally)
//   fifo_empty_i     : FIFO empty flag
//   fifo_rd_valid_o  : pop strobe to the FIFO
//   cmd_valid_i/cmd_ready_o/cmd_len_i : burst command (len = beats - 1)
//   m_data_o/m_last_o/m_valid_o/m_ready_i : output beat channel
//   busy_o           : a burst is in progress
// Valid/ready: a transfer happens on a rising edge where valid and ready are
// both high; once valid rises it and its payload hold until accepted.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_valid_o,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  busy_o
);

  state_t                state_q;
  state_t                state_nxt;
  logic [LEN_WIDTH-1:0]  pop_cnt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [1:0]            buf_count;
  logic                  pop;
  logic                  pop_last;
  logic [DATA_WIDTH:0]   head;

  assign pop_last = (pop_cnt == len_q);

  // Pop depends only on registered state/count and the FIFO flag, never on
  // m_ready_i, so the downstream ready has no path to the FIFO.
  always_comb begin
    state_nxt   = state_q;
    cmd_ready_o = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_nxt = BURST;
      end
      BURST: begin
        pop = !fifo_empty_i && (buf_count != 2'd2);
        if (pop && pop_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (m_valid_o && m_ready_i && m_last_o) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pop_cnt <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == IDLE && cmd_valid_i) begin
        len_q   <= cmd_len_i;
        pop_cnt <= '0;
      end else if (pop && !pop_last) begin
        // Holding at len_q on the final pop keeps an all-ones length from wrapping.
        pop_cnt <= pop_cnt + 1'b1;
      end
    end
  end

  assign fifo_rd_valid_o = pop;
  assign busy_o          = (state_q != IDLE);

  beat_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (pop),
    .push_data ({pop_last, fifo_data_i}),
    .ready     (m_ready_i),
    .valid     (m_valid_o),
    .data      (head),
    .count     (buf_count)
  );

  assign m_last_o = head[DATA_WIDTH];
  assign m_data_o = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_empty_i;
  logic          fifo_rd_valid_o;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [LW-1:0] cmd_len_i;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          busy_o;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_data_i     (fifo_data_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_rd_valid_o (fifo_rd_valid_o),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_len_i       (cmd_len_i),
    .m_data_o        (m_data_o),
    .m_last_o        (m_last_o),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready_i),
    .busy_o          (busy_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model / scoreboard state ----------------
  logic [DW-1:0] fifo_q[$];   // the FIFO feeding the DUT
  logic [DW:0]   exp_q[$];    // {last,data} beats popped but not yet accepted
  logic [DW:0]   acc_log[$];  // accepted beats, cleared per scenario
  int            pop_cyc[$];  // edges at which the DUT popped
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int remaining = 0;          // beats of the current command still to pop
  bit active = 0;             // a command is accepted and its last beat not yet taken
  bit hs_flag = 0;
  int hs_cyc = -1;
  int last_acc_cyc = -1;
  int act_pops = 0;
  bit rand_mode = 0;

  task automatic update_fifo_inputs();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic fifo_write(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    update_fifo_inputs();
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    remaining = 0;
    active = 0;
  endtask

  // One clock: check the DUT against the model at the falling edge, then
  // advance the model by the transfers that the rules say happen at the edge.
  task automatic cycle();
    bit exp_pop, exp_valid, acc, hs;
    logic [DW:0] b;
    logic [DW-1:0] w;
    @(negedge clk);
    exp_pop   = (remaining > 0) && (fifo_q.size() > 0) && (exp_q.size() < 2);
    exp_valid = (exp_q.size() != 0);
    checks++;
    if (fifo_rd_valid_o !== exp_pop) begin
      failures++;
      $display("FAIL pop cyc=%0d got=%0b exp=%0b", cyc, fifo_rd_valid_o, exp_pop);
    end
    checks++;
    if (m_valid_o !== exp_valid) begin
      failures++;
      $display("FAIL m_valid cyc=%0d got=%0b exp=%0b", cyc, m_valid_o, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if ({m_last_o, m_data_o} !== exp_q[0]) begin
        failures++;
        $display("FAIL beat cyc=%0d got=%0h exp=%0h", cyc, {m_last_o, m_data_o}, exp_q[0]);
      end
    end
    checks++;
    if (cmd_ready_o !== !active) begin
      failures++;
      $display("FAIL cmd_ready cyc=%0d got=%0b exp=%0b", cyc, cmd_ready_o, !active);
    end
    checks++;
    if (busy_o !== active) begin
      failures++;
      $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy_o, active);
    end
    if (fifo_rd_valid_o === 1'b1) act_pops++;
    acc = exp_valid && m_ready_i;
    hs  = cmd_valid_i && !active;
    @(posedge clk);
    cyc++;
    #1;
    if (fifo_rd_valid_o === 1'b1 || exp_pop) ; // settle point
    if (acc) begin
      b = exp_q.pop_front();
      acc_log.push_back(b);
      if (b[DW]) begin
        active = 0;
        last_acc_cyc = cyc;
      end
    end
    if (exp_pop) begin
      w = fifo_q.pop_front();
      remaining--;
      exp_q.push_back({(remaining == 0), w});
      pop_cyc.push_back(cyc);
    end
    if (hs) begin
      active = 1;
      remaining = int'(cmd_len_i) + 1;
      hs_flag = 1;
      hs_cyc = cyc;
    end
    if (rand_mode) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 8)
        fifo_q.push_back(DW'($urandom));
    end
    update_fifo_inputs();
  endtask

  task automatic send_cmd(input int len);
    cmd_len_i = LW'(len);
    cmd_valid_i = 1'b1;
    hs_flag = 0;
    for (int i = 0; i < 2000 && !hs_flag; i++) cycle();
    cmd_valid_i = 1'b0;
    checks++;
    if (!hs_flag) begin
      failures++;
      $display("FAIL cmd_handshake_timeout got=0 exp=1");
    end
  endtask

  task automatic run_until_idle(input int limit);
    int n = 0;
    while ((active || exp_q.size() != 0) && n < limit) begin
      cycle();
      n++;
    end
    checks++;
    if (active || exp_q.size() != 0) begin
      failures++;
      $display("FAIL idle_timeout got_active=%0b exp=0", active);
    end
  endtask

  task automatic check_log(input string name, input logic [DW:0] exp[$]);
    checks++;
    if (acc_log.size() != exp.size()) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", name, acc_log.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (acc_log[i] !== exp[i]) begin
          failures++;
          $display("FAIL %s_beat%0d got=%0h exp=%0h", name, i, acc_log[i], exp[i]);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_len_i = '0;
    m_ready_i = 1'b1;
    model_reset();
    update_fifo_inputs();
    #1;
    checks++;
    if ({m_valid_o, m_last_o, m_data_o, fifo_rd_valid_o, busy_o, cmd_ready_o} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs got=%0b_%0b_%0h_%0b_%0b_%0b exp=0_0_0_0_0_1",
               m_valid_o, m_last_o, m_data_o, fifo_rd_valid_o, busy_o, cmd_ready_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW:0] exp[$];
    acc_log.delete();
    pop_cyc.delete();
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) fifo_write(DW'(8'hA0 + i));
    send_cmd(3);
    run_until_idle(50);
    exp = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h1A3};
    check_log("basic", exp);
    checks++;
    if (pop_cyc.size() != 4 || pop_cyc[3] - pop_cyc[0] != 3) begin
      failures++;
      $display("FAIL basic_consecutive_pops got=%0d exp=4", pop_cyc.size());
    end
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_cmd_ready_after got=%0b exp=1", cmd_ready_o);
    end
  endtask

  task automatic test_single();
    logic [DW:0] exp[$];
    int p0;
    acc_log.delete();
    fifo_write(8'h5A);
    fifo_write(8'h77);
    p0 = act_pops;
    send_cmd(0);
    run_until_idle(50);
    repeat (3) cycle();
    exp = '{9'h15A};
    check_log("single", exp);
    checks++;
    if (act_pops - p0 != 1 || fifo_empty_i !== 1'b0) begin
      failures++;
      $display("FAIL single_pop_count got=%0d exp=1", act_pops - p0);
    end
    fifo_q.delete();
    update_fifo_inputs();
  endtask

  task automatic test_backpressure();
    logic [DW:0] exp[$];
    int p0;
    acc_log.delete();
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(DW'(8'hA0 + i));
    send_cmd(3);
    p0 = act_pops;
    repeat (5) cycle();
    checks++;
    if (act_pops - p0 != 2) begin
      failures++;
      $display("FAIL bp_pops got=%0d exp=2", act_pops - p0);
    end
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 8'hA0) begin
      failures++;
      $display("FAIL bp_hold got=%0b_%0h exp=1_a0", m_valid_o, m_data_o);
    end
    m_ready_i = 1'b1;
    run_until_idle(50);
    exp = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h1A3};
    check_log("bp", exp);
  endtask

  task automatic test_empty_gap();
    logic [DW:0] exp[$];
    acc_log.delete();
    m_ready_i = 1'b1;
    fifo_write(8'hB0);
    send_cmd(2);
    repeat (4) cycle();
    checks++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL gap_valid got=%0b_%0b exp=0_1", m_valid_o, busy_o);
    end
    fifo_write(8'hB1);
    fifo_write(8'hB2);
    run_until_idle(50);
    exp = '{9'h0B0, 9'h0B1, 9'h1B2};
    check_log("gap", exp);
  endtask

  task automatic test_back_to_back();
    logic [DW:0] exp[$];
    acc_log.delete();
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) fifo_write(DW'(8'hC0 + i));
    send_cmd(1);
    send_cmd(1);
    checks++;
    if (hs_cyc <= last_acc_cyc) begin
      failures++;
      $display("FAIL b2b_second_hs got=%0d exp_gt=%0d", hs_cyc, last_acc_cyc);
    end
    run_until_idle(50);
    exp = '{9'h0C0, 9'h1C1, 9'h0C2, 9'h1C3};
    check_log("b2b", exp);
  endtask

  task automatic test_reset_mid();
    logic [DW:0] exp[$];
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) fifo_write(DW'(8'hD0 + i));
    send_cmd(5);
    repeat (2) cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_valid_o, busy_o, cmd_ready_o, fifo_rd_valid_o, m_data_o} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL async_reset got=%0b_%0b_%0b_%0b_%0h exp=0_0_1_0_0",
               m_valid_o, busy_o, cmd_ready_o, fifo_rd_valid_o, m_data_o);
    end
    model_reset();
    update_fifo_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready_i = 1'b1;
    acc_log.delete();
    fifo_write(8'h5A);
    send_cmd(0);
    run_until_idle(50);
    exp = '{9'h15A};
    check_log("post_reset", exp);
  endtask

  task automatic test_random();
    rand_mode = 1;
    for (int b = 0; b < 12; b++) begin
      send_cmd((b == 5) ? 255 : int'($urandom_range(0, 15)));
      run_until_idle(4000);
    end
    rand_mode = 0;
    m_ready_i = 1'b1;
    repeat (3) cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_empty_gap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
